led_blink_driver: RTL and testbench
===================================

Name: led_blink_driver

Overview:
- Output-side counterpart to the button input path: turns 1-cycle event pulses (button edges, status strobes) into human-visible LED blinks.
- Each accepted event produces one blink: LED on for ON_CYCLES, then forced off for GAP_CYCLES.
- Events arriving mid-blink are counted in a saturating pending counter and replayed back-to-back.
- Sits between control logic and board LED pins.

Parameters:
ON_CYCLES, 12500000, LED-on duration per blink in clk cycles (>=1)
GAP_CYCLES, 12500000, forced LED-off duration after each blink (>=1)
PEND_W, 4, pending counter width; max queued events = 2^PEND_W-1

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
evt  input  1  event strobe; every cycle high counts as one event
clr_ovf  input  1  clears overflow flag
led  output  1  LED drive, active-high, registered
busy  output  1  high whenever state != IDLE
pending  output  PEND_W  queued blinks not yet started
overflow  output  1  sticky: an event was dropped due to saturation

Behaviour:
- Reset: state=IDLE, led=0, busy=0, pending=0, overflow=0, timer=0. Reset mid-blink aborts immediately (led=0 on next edge); queued events are discarded.
- Timer width: $clog2(max(ON_CYCLES,GAP_CYCLES)+1); counts down.
- FSM states: IDLE, ON, GAP.
- IDLE, evt=1: go to ON, load timer=ON_CYCLES-1. led=1 from the next cycle (1-cycle latency). pending stays unchanged.
- ON: led=1. At timer==0, go to GAP and load timer=GAP_CYCLES-1.
- GAP: led=0. At timer==0:
  - pending>0 or evt=1: go to ON, load timer=ON_CYCLES-1. No IDLE cycle is inserted.
  - otherwise: go to IDLE.
- Result: led is high exactly ON_CYCLES cycles and low at least GAP_CYCLES cycles per blink.
- Pending update per cycle:
  - inc: evt=1 and the event is not consumed directly.
  - dec: last GAP cycle with pending>0.
  - Direct consumption: evt in IDLE, or evt on the last GAP cycle with pending==0.
  - inc and dec in the same cycle: pending unchanged.
  - inc at pending==2^PEND_W-1: event dropped, pending holds, overflow<=1.
- overflow: sticky. Cleared by clr_ovf (1-cycle effect). If clr_ovf and a new drop occur in the same cycle, set wins.
- busy is combinational from state; led is registered.

Optional Feature:
- Macro: LED_BLINK_PWM_EN.
- Defined:
  - Adds input brightness[7:0] and an internal free-running 8-bit PWM counter, reset to 0.
  - led = (state==ON) & (pwm_cnt < brightness). brightness=0 gives a dark blink; 255 gives 255/256 duty.
  - Blink timing, pending and busy are unchanged.
- Undefined: no brightness port; led is solid during ON.

Decomposition:
- Shared package led_pkg:
  - state enum (IDLE/ON/GAP, 2 bits).
  - default timing localparams (LED_ON_DEFAULT, LED_GAP_DEFAULT).
  - PWM width constant.
- Natural sub-module: led_pwm_gen (8-bit counter plus compare), instantiated only under LED_BLINK_PWM_EN.
- FSM, timer and pending counter stay in the top module.

Test Plan (ON_CYCLES=4, GAP_CYCLES=3, PEND_W=2):
- Reset held 2 cycles, evt=1 during reset -> led=0, busy=0, pending=0, overflow=0 after release; no blink starts.
- Single evt at cycle t -> led=1 cycles t+1..t+4, led=0 t+5..t+7, busy=0 from t+8.
- evt at t and t+2 -> pending=1 during t+3..t+7; second blink led=1 t+8..t+11; pending=0 from t+8.
- evt at t, then evt held high t+1..t+5 -> pending saturates at 3, overflow=1; exactly 4 blinks total; clr_ovf pulse afterward -> overflow=0.
- pending=0 and evt on the final GAP cycle -> led rises the next cycle with no IDLE cycle; pending stays 0.
- rst asserted in the 2nd ON cycle with pending=2 -> next cycle led=0, busy=0, pending=0; no further blinks.

Source files
------------

// File: rtl/led_pkg.sv
//------------------------------------------------------------------------------
// Module   : led_pkg
// Purpose  : Shared state encoding, default blink timing and PWM width for
//            the LED blink driver.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } led_state_t;

    // Roughly 250 ms per phase at a 50 MHz board clock
    localparam int LED_ON_DEFAULT  = 12500000;
    localparam int LED_GAP_DEFAULT = 12500000;

    localparam int LED_PWM_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_pwm_gen.sv
//------------------------------------------------------------------------------
// Module   : led_pwm_gen
// Purpose  : Free-running 8-bit PWM counter with brightness compare.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_pwm_gen
    import led_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LED_PWM_W-1:0] brightness,
    output logic                 pwm_hi
);

    logic [LED_PWM_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + LED_PWM_W'(1);
        end
    end

    // Full-scale 255 leaves the count-255 slot dark: 255/256 duty
    assign pwm_hi = (r_cnt < brightness);

endmodule

`default_nettype wire

// File: rtl/led_blink_driver.sv
//------------------------------------------------------------------------------
// Module   : led_blink_driver
// Purpose  : Stretches 1-cycle event strobes into visible LED blinks with a
//            saturating queue of pending blinks. Optional brightness PWM is
//            enabled by defining LED_BLINK_PWM_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_blink_driver
    import led_pkg::*;
#(
    parameter int ON_CYCLES  = LED_ON_DEFAULT,
    parameter int GAP_CYCLES = LED_GAP_DEFAULT,
    parameter int PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              evt,
    input  logic              clr_ovf,
`ifdef LED_BLINK_PWM_EN
    input  logic [LED_PWM_W-1:0] brightness,
`endif
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int c_TMR_W = $clog2(max_int(ON_CYCLES, GAP_CYCLES) + 1);

    localparam logic [c_TMR_W-1:0] c_ON_LOAD  = c_TMR_W'(ON_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LOAD = c_TMR_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0]  c_PEND_MAX = {PEND_W{1'b1}};

    led_state_t          r_state;
    led_state_t          w_next_state;
    logic [c_TMR_W-1:0]  r_timer;
    logic [PEND_W-1:0]   r_pending;
    logic                r_overflow;
    logic                r_led;

    logic w_timer_zero;
    logic w_pend_nz;
    logic w_pend_full;
    logic w_load_on;
    logic w_load_gap;
    logic w_direct;
    logic w_inc;
    logic w_dec;
    logic w_drop;
    logic w_pwm_hi;

`ifdef LED_BLINK_PWM_EN
    led_pwm_gen u_pwm (
        .clk        (clk),
        .rst        (rst),
        .brightness (brightness),
        .pwm_hi     (w_pwm_hi)
    );
`else
    assign w_pwm_hi = 1'b1;
`endif

    assign w_timer_zero = (r_timer == '0);
    assign w_pend_nz    = (r_pending != '0);
    assign w_pend_full  = (r_pending == c_PEND_MAX);

    always_comb begin
        w_next_state = r_state;
        w_load_on    = 1'b0;
        w_load_gap   = 1'b0;
        w_direct     = 1'b0;
        w_dec        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (evt) begin
                    w_next_state = ST_ON;
                    w_load_on    = 1'b1;
                    w_direct     = 1'b1;
                end
            end
            ST_ON: begin
                if (w_timer_zero) begin
                    w_next_state = ST_GAP;
                    w_load_gap   = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_timer_zero) begin
                    // Queued blinks take priority; a fresh event only starts
                    // the next blink directly when the queue is empty
                    if (w_pend_nz) begin
                        w_next_state = ST_ON;
                        w_load_on    = 1'b1;
                        w_dec        = 1'b1;
                    end else if (evt) begin
                        w_next_state = ST_ON;
                        w_load_on    = 1'b1;
                        w_direct     = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_inc  = evt & ~w_direct;
    assign w_drop = w_inc & ~w_dec & w_pend_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_pending  <= '0;
            r_overflow <= 1'b0;
            r_led      <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_load_on) begin
                r_timer <= c_ON_LOAD;
            end else if (w_load_gap) begin
                r_timer <= c_GAP_LOAD;
            end else if (!w_timer_zero) begin
                r_timer <= r_timer - c_TMR_W'(1);
            end

            if (w_inc && !w_dec && !w_pend_full) begin
                r_pending <= r_pending + PEND_W'(1);
            end else if (w_dec && !w_inc) begin
                r_pending <= r_pending - PEND_W'(1);
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end

            r_led <= (w_next_state == ST_ON) & w_pwm_hi;
        end
    end

    assign led      = r_led;
    assign busy     = (r_state != ST_IDLE);
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_led_blink_driver.sv
//------------------------------------------------------------------------------
// Module   : tb_led_blink_driver
// Purpose  : Self-checking bench for led_blink_driver (ON=4, GAP=3, PEND_W=2).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_led_blink_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       evt = 1'b1;
    logic       clr_ovf = 1'b0;
    logic       led;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;
`ifdef LED_BLINK_PWM_EN
    logic [7:0] brightness = 8'hFF;
`endif

    always #5 clk = ~clk;

    led_blink_driver #(
        .ON_CYCLES  (4),
        .GAP_CYCLES (3),
        .PEND_W     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .evt        (evt),
        .clr_ovf    (clr_ovf),
`ifdef LED_BLINK_PWM_EN
        .brightness (brightness),
`endif
        .led        (led),
        .busy       (busy),
        .pending    (pending),
        .overflow   (overflow)
    );

    // Expected fields are the outputs seen after the edge that samples the row
    typedef struct {
        string      name;
        logic       rst;
        logic       evt;
        logic       clr;
        logic [4:0] exp;  // {led, busy, pending[1:0], overflow}
    } vec_t;

    vec_t       vecs[$];
    logic [4:0] exp_q[$];
    string      tag_q[$];
    int         checks   = 0;
    int         failures = 0;

    task automatic add(input string n, input logic r, input logic e, input logic c,
                       input logic l, input logic b, input logic [1:0] p, input logic o);
        vec_t v;
        v.name = n; v.rst = r; v.evt = e; v.clr = c; v.exp = {l, b, p, o};
        vecs.push_back(v);
    endtask

    task automatic add_n(input int n, input string nm, input logic l, input logic b,
                         input logic [1:0] p, input logic o);
        for (int k = 0; k < n; k++) add(nm, 1'b0, 1'b0, 1'b0, l, b, p, o);
    endtask

    initial begin
        logic [4:0] act;
        logic [4:0] e;
        string      t;
        int         on_cnt;
        int         busy_cnt;
        int         n;

        // Reset with evt high must not launch a blink
        add("reset", 1, 1, 0, 0, 0, 2'd0, 0);
        add("reset", 1, 1, 0, 0, 0, 2'd0, 0);
        add_n(2, "reset", 0, 0, 2'd0, 0);

        // Single event
        add("single", 0, 1, 0, 1, 1, 2'd0, 0);
        add_n(3, "single", 1, 1, 2'd0, 0);
        add_n(3, "single", 0, 1, 2'd0, 0);
        add_n(2, "single", 0, 0, 2'd0, 0);

        // Second event mid-blink is queued and replayed
        add("two", 0, 1, 0, 1, 1, 2'd0, 0);
        add_n(1, "two", 1, 1, 2'd0, 0);
        add("two", 0, 1, 0, 1, 1, 2'd1, 0);
        add_n(1, "two", 1, 1, 2'd1, 0);
        add_n(3, "two", 0, 1, 2'd1, 0);
        add_n(4, "two", 1, 1, 2'd0, 0);
        add_n(3, "two", 0, 1, 2'd0, 0);
        add_n(1, "two", 0, 0, 2'd0, 0);

        // Saturation, dropped events, four blinks, overflow clear
        add("sat", 0, 1, 0, 1, 1, 2'd0, 0);
        add("sat", 0, 1, 0, 1, 1, 2'd1, 0);
        add("sat", 0, 1, 0, 1, 1, 2'd2, 0);
        add("sat", 0, 1, 0, 1, 1, 2'd3, 0);
        add("sat", 0, 1, 0, 0, 1, 2'd3, 1);
        add("sat", 0, 1, 0, 0, 1, 2'd3, 1);
        add_n(1, "sat", 0, 1, 2'd3, 1);
        add_n(4, "sat", 1, 1, 2'd2, 1);
        add_n(3, "sat", 0, 1, 2'd2, 1);
        add_n(4, "sat", 1, 1, 2'd1, 1);
        add_n(3, "sat", 0, 1, 2'd1, 1);
        add_n(4, "sat", 1, 1, 2'd0, 1);
        add_n(3, "sat", 0, 1, 2'd0, 1);
        add_n(1, "sat", 0, 0, 2'd0, 1);
        add("sat_clr", 0, 0, 1, 0, 0, 2'd0, 0);
        add_n(1, "sat_clr", 0, 0, 2'd0, 0);

        // Event on the final GAP cycle with nothing queued
        add("b2b", 0, 1, 0, 1, 1, 2'd0, 0);
        add_n(3, "b2b", 1, 1, 2'd0, 0);
        add_n(3, "b2b", 0, 1, 2'd0, 0);
        add("b2b", 0, 1, 0, 1, 1, 2'd0, 0);
        add_n(3, "b2b", 1, 1, 2'd0, 0);
        add_n(3, "b2b", 0, 1, 2'd0, 0);
        add_n(1, "b2b", 0, 0, 2'd0, 0);

        // Reset in the 2nd ON cycle of a blink while two blinks are queued
        add("rstmid", 0, 1, 0, 1, 1, 2'd0, 0);
        add("rstmid", 0, 1, 0, 1, 1, 2'd1, 0);
        add("rstmid", 0, 1, 0, 1, 1, 2'd2, 0);
        add("rstmid", 0, 1, 0, 1, 1, 2'd3, 0);
        add_n(3, "rstmid", 0, 1, 2'd3, 0);
        add_n(2, "rstmid", 1, 1, 2'd2, 0);
        add("rstmid", 1, 0, 0, 0, 0, 2'd0, 0);
        add_n(5, "rstmid", 0, 0, 2'd0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst     = vecs[i].rst;
            evt     = vecs[i].evt;
            clr_ovf = vecs[i].clr;
            exp_q.push_back(vecs[i].exp);
            tag_q.push_back($sformatf("%s@%0d", vecs[i].name, i));
            @(posedge clk);
            #1;
            act = {led, busy, pending, overflow};
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s {led,busy,pend,ovf} got=%b exp=%b", t, act, e);
            end
        end

        // Whole-blink timing measured from one isolated event
        @(negedge clk);
        evt = 1'b1;
        @(posedge clk);
        #1;
        evt      = 1'b0;
        on_cnt   = 0;
        busy_cnt = 0;
        n        = 0;
        while (busy && n < 40) begin
            if (led) on_cnt++;
            busy_cnt++;
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL blink_timeout busy_cycles got=%0d exp=7", busy_cnt);
        end
        checks++;
        if (on_cnt != 4) begin
            failures++;
            $display("FAIL blink_on_len got=%0d exp=4", on_cnt);
        end
        checks++;
        if (busy_cnt != 7) begin
            failures++;
            $display("FAIL blink_busy_len got=%0d exp=7", busy_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
